// File: rtl/data_mem_wait_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_wait_ctrl_pkg
// Brief    : Shared types and constants for the wait-state data-memory
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_wait_ctrl_pkg;

  localparam int unsigned MAX_WAIT_CYCLES = 15;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    MEMC_IDLE   = 2'd0,
    MEMC_WAIT   = 2'd1,
    MEMC_ACCESS = 2'd2,
    MEMC_RESP   = 2'd3
  } memc_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_wait_ctrl_dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Synchronous single-port word array with registered,
//            write-first read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import data_mem_wait_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr_idx,
  input  logic [DATA_LEN-1:0]   wdata,
  output logic [DATA_LEN-1:0]   rdata_q
);

  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];

  // Contents deliberately survive reset; only the clock touches the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr_idx] <= wdata;
      rdata_q        <= wdata;
    end else begin
      rdata_q        <= mem[waddr_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_wait_ctrl
// Brief    : Variable-latency data-memory controller: one request per
//            handshake, WAIT_CYCLES wait states, single-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_wait_ctrl
  import data_mem_wait_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN    = 32,
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  memc_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;

  logic [DEPTH_LOG2-1:0] idx_lat;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [DATA_LEN-1:0]   arr_rdata;
  logic                  arr_we;
  logic                  addr_err;

  assign idx_lat  = addr_q[DEPTH_LOG2+1:2];
  assign idx_in   = req_addr[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    (addr_q[ADDR_LEN-1:DEPTH_LOG2+2] != '0);

  // The array is addressed with the incoming request while idle so that its
  // registered read already holds the target word by the ACCESS edge.
  assign arr_idx = (state_q == MEMC_IDLE) ? idx_in : idx_lat;
  assign arr_we  = (state_q == MEMC_ACCESS) && write_q && !addr_err;

  dmem_array #(
    .DATA_LEN   (DATA_LEN),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_dmem (
    .clk       (clk),
    .we        (arr_we),
    .waddr_idx (arr_idx),
    .wdata     (wdata_q),
    .rdata_q   (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      MEMC_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT != '0) ? MEMC_WAIT : MEMC_ACCESS;
        end
      end
      MEMC_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MEMC_ACCESS;
        end
      end
      MEMC_ACCESS: begin
        state_d = MEMC_RESP;
        rdata_d = (!write_q && !addr_err) ? arr_rdata : '0;
      end
      MEMC_RESP: begin
        state_d = MEMC_IDLE;
      end
      default: begin
        state_d = MEMC_IDLE;
      end
    endcase

    // Outputs are registered: decode them from the state being entered.
    ready_d = (state_d == MEMC_IDLE);
    valid_d = (state_d == MEMC_RESP);
    err_d   = (state_d == MEMC_RESP) && addr_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEMC_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_wait_ctrl
// Brief    : Scoreboard bench driving a WAIT_CYCLES=2 and a WAIT_CYCLES=0
//            controller from shared request signals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_wait_ctrl;

  localparam int W_A = 2;
  localparam int W_B = 0;

  typedef struct {
    int          inst;
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic        st;
    int          idx;
    logic [31:0] wdata;
  } sb_t;

  sb_t exp_q[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        rdy [2];
  logic        rv  [2];
  logic        re  [2];
  logic [31:0] rd  [2];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_to [2] = '{-1, -1};
  logic [31:0] ref_mem [2][1024];

  data_mem_wait_ctrl #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[0]), .resp_rdata(rd[0]),
    .resp_err(re[0])
  );

  data_mem_wait_ctrl #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[1]), .resp_rdata(rd[1]),
    .resp_err(re[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(int i);
    return (i == 0) ? W_A : W_B;
  endfunction

  function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endfunction

  // Reference model: a request is taken whenever valid is seen while the
  // instance is outside its busy window; the outcome follows from the address.
  always @(posedge clk) begin
    sb_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy_to[i] <= -1;
        for (int k = exp_q.size() - 1; k >= 0; k--)
          if (exp_q[k].inst == i) exp_q.delete(k);
      end else if (req_valid && cyc > busy_to[i]) begin
        e.inst  = i;
        e.err   = (req_addr % 4 != 0) || (req_addr >= 32'd4096);
        e.idx   = int'((req_addr / 4) % 1024);
        e.st    = req_write && !e.err;
        e.wdata = req_wdata;
        e.rdata = (req_write || e.err) ? 32'h0 : ref_mem[i][e.idx];
        e.due   = cyc + wait_of(i) + 2;
        busy_to[i] <= cyc + wait_of(i) + 2;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: checks handshake readiness every cycle and pops on each response.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_ready", i, 32'(rdy[i]), 32'h1);
        chk("rst_valid", i, 32'(rv[i]), 32'h0);
        chk("rst_err", i, 32'(re[i]), 32'h0);
        chk("rst_rdata", i, rd[i], 32'h0);
      end else begin
        int k;
        k = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (k < 0 && exp_q[j].inst == i) k = j;
        chk("ready", i, 32'(rdy[i]), 32'(cyc > busy_to[i]));
        if (rv[i]) begin
          if (k < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp inst%0d cyc %0d: got resp_valid=1 expected 0", i, cyc);
          end else begin
            chk("latency", i, 32'(cyc), 32'(exp_q[k].due));
            chk("resp_err", i, 32'(re[i]), 32'(exp_q[k].err));
            chk("resp_rdata", i, rd[i], exp_q[k].rdata);
            if (exp_q[k].st) ref_mem[i][exp_q[k].idx] = exp_q[k].wdata;
            exp_q.delete(k);
          end
        end else begin
          chk("err_outside_resp", i, 32'(re[i]), 32'h0);
          if (k >= 0 && cyc > exp_q[k].due) begin
            checks++;
            errors++;
            $display("FAIL missing_resp inst%0d cyc %0d: got no resp expected one at cyc %0d",
                     i, cyc, exp_q[k].due);
            exp_q.delete(k);
          end
        end
      end
    end
  end

  // Issue one request once both controllers are idle; called at posedge+1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      $display("FAIL ready_timeout cyc %0d: got req_ready low expected high within 50 cycles", cyc);
      $fatal(1, "ready timeout");
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    repeat (hold) @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    logic [31:0] a;
    idle(3);
    rst = 1'b0;
    idle(3);

    for (int k = 0; k < 16; k++) issue(1'b1, 32'(k * 4), $urandom, 1);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 1);
    issue(1'b0, 32'h10, 32'h0, 1);
    issue(1'b1, 32'h13, 32'h12345678, 1);
    issue(1'b0, 32'h10, 32'h0, 1);
    issue(1'b0, 32'h1000, 32'h0, 5);
    issue(1'b1, 32'h0, 32'h5, 1);
    issue(1'b0, 32'h0, 32'h0, 1);

    issue(1'b1, 32'h20, 32'hAA, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    issue(1'b0, 32'h20, 32'h0, 1);

    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 32'($urandom_range(0, 15)) * 4;
      else if (r < 8) a = (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(1, 3));
      else            a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      issue(1'($urandom_range(0, 1)), a, $urandom, (r == 9) ? 4 : 1);
      idle(int'($urandom_range(0, 2)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
